// File: rtl/comparator_multicycle_if.sv
// Request/response bundle for the multi-cycle comparator.
// The master drives the request (start, mode, operands); the slave returns
// busy plus a registered result that is qualified by the one-cycle done pulse.
interface comparator_multicycle_if #(
   parameter int N = 32
);
   logic         start;
   logic [2:0]   mode;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic         out;
   logic         err;

   modport master (
      output start, mode, a, b,
      input  busy, done, out, err
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, out, err
   );
endinterface

// File: rtl/comparator_multicycle.sv
// Multi-cycle branch comparator: walks the operands W bits at a time from the
// most-significant chunk down, stops at the first differing chunk and reports
// one of the six branch conditions selected by a funct3-style mode.
module comparator_multicycle #(
   parameter int N = 32,
   parameter int W = 8
) (
   input logic               clk,
   input logic               rst,
   comparator_multicycle_if.slave bus
);

   localparam int NC    = N / W;
   localparam int IW    = (NC > 1) ? $clog2(NC) : 1;
   localparam int DEPTH = 1 << IW;

   typedef enum logic {
      IDLE,
      COMPARE
   } state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [N-1:0]    a_reg, a_next;
   logic [N-1:0]    b_reg, b_next;
   logic [2:0]      mode_reg, mode_next;
   logic            done_reg, done_next;
   logic            out_reg, out_next;
   logic            err_reg, err_next;

   // Chunk tables are padded to a power of two so any idx value selects
   // a defined entry; unused entries read as zero.
   logic [W-1:0]    ca_arr [DEPTH];
   logic [W-1:0]    cb_arr [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_chunk
         if (gi < NC) begin : g_used
            assign ca_arr[gi] = a_reg[gi*W +: W];
            assign cb_arr[gi] = b_reg[gi*W +: W];
         end else begin : g_pad
            assign ca_arr[gi] = '0;
            assign cb_arr[gi] = '0;
         end
      end
   endgenerate

   logic [W-1:0] ca, cb;
   logic         flip;
   logic         finish;
   logic         eq;
   logic         lt;

   // Current chunk pair; the top chunk of a signed compare has its sign bit
   // inverted so two's-complement order becomes plain unsigned order.
   always_comb begin
      flip       = (idx_reg == IW'(NC - 1)) && !mode_reg[1];
      ca         = ca_arr[idx_reg];
      cb         = cb_arr[idx_reg];
      ca[W-1]    = ca[W-1] ^ flip;
      cb[W-1]    = cb[W-1] ^ flip;
   end

   // Next-state and result logic for the IDLE/COMPARE controller.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      mode_next  = mode_reg;
      done_next  = 1'b0;
      out_next   = out_reg;
      err_next   = err_reg;
      finish     = 1'b0;
      eq         = 1'b0;
      lt         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               a_next     = bus.a;
               b_next     = bus.b;
               mode_next  = bus.mode;
               idx_next   = IW'(NC - 1);
               state_next = COMPARE;
            end
         end
         COMPARE: begin
            if (ca != cb) begin
               finish = 1'b1;
               lt     = (ca < cb);
            end else if (idx_reg == '0) begin
               finish = 1'b1;
               eq     = 1'b1;
            end else begin
               idx_next = idx_reg - IW'(1);
            end

            if (finish) begin
               state_next = IDLE;
               done_next  = 1'b1;
               if (mode_reg[2:1] == 2'b01) begin
                  out_next = 1'b0;
                  err_next = 1'b1;
               end else begin
                  out_next = (mode_reg[2] ? lt : eq) ^ mode_reg[0];
                  err_next = 1'b0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         mode_reg  <= '0;
         done_reg  <= 1'b0;
         out_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         mode_reg  <= mode_next;
         done_reg  <= done_next;
         out_reg   <= out_next;
         err_reg   <= err_next;
      end
   end

   assign bus.busy = (state_reg == COMPARE);
   assign bus.done = done_reg;
   assign bus.out  = out_reg;
   assign bus.err  = err_reg;

endmodule

// File: tb/tb_comparator_multicycle.sv
// Directed bench: three comparator instances (W=8, W=32, W=1) share the same
// request stream; each transaction records done cycle, out and err per width.
module tb_comparator_multicycle;

   localparam logic [2:0] M_EQ  = 3'b000;
   localparam logic [2:0] M_NE  = 3'b001;
   localparam logic [2:0] M_ILL = 3'b010;
   localparam logic [2:0] M_LT  = 3'b100;
   localparam logic [2:0] M_GE  = 3'b101;
   localparam logic [2:0] M_LTU = 3'b110;
   localparam logic [2:0] M_GEU = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  mode;
   logic [31:0] a;
   logic [31:0] b;

   always #5 clk = ~clk;

   comparator_multicycle_if #(.N(32)) if8  ();
   comparator_multicycle_if #(.N(32)) if32 ();
   comparator_multicycle_if #(.N(32)) if1  ();

   assign if8.start  = start;
   assign if8.mode   = mode;
   assign if8.a      = a;
   assign if8.b      = b;
   assign if32.start = start;
   assign if32.mode  = mode;
   assign if32.a     = a;
   assign if32.b     = b;
   assign if1.start  = start;
   assign if1.mode   = mode;
   assign if1.a      = a;
   assign if1.b      = b;

   comparator_multicycle #(.N(32), .W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
   comparator_multicycle #(.N(32), .W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
   comparator_multicycle #(.N(32), .W(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

   logic [2:0] done_v, busy_v, out_v, err_v;
   assign done_v = {if1.done, if32.done, if8.done};
   assign busy_v = {if1.busy, if32.busy, if8.busy};
   assign out_v  = {if1.out,  if32.out,  if8.out};
   assign err_v  = {if1.err,  if32.err,  if8.err};

   int vectors     = 0;
   int miscompares = 0;

   // Per-instance capture of the most recent transaction (index 0=W8, 1=W32, 2=W1).
   int   m_lat [3];
   logic m_out [3];
   logic m_err [3];
   logic m_busy1;
   logic m_done_after;

   typedef struct {
      logic [2:0]  m;
      logic [31:0] a;
      logic [31:0] b;
      logic        eo;
      logic        ee;
      int          l8;
      int          l32;
      int          l1;
   } vec_t;

   function automatic string dname(input int i);
      if (i == 0) return "W8";
      if (i == 1) return "W32";
      return "W1";
   endfunction

   // Issue one request and record, per instance, the cycle of the first done
   // pulse with out/err. Operands and mode are scrambled after cycle 0, and
   // start is optionally pulsed with unrelated operands in cycles pf..pt.
   task automatic measure(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                          input int pf, input int pt);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
      mode  = m ^ 3'b001;
      for (int i = 0; i < 3; i++) begin
         m_lat[i] = -1;
         m_out[i] = 1'bx;
         m_err[i] = 1'bx;
      end
      m_busy1      = 1'bx;
      m_done_after = 1'bx;
      cyc = 1;
      while (cyc <= 40 &&
             !(m_lat[0] >= 0 && m_lat[1] >= 0 && m_lat[2] >= 0 && cyc > m_lat[0] + 1)) begin
         if (cyc == 1) m_busy1 = busy_v[0];
         if (m_lat[0] >= 0 && cyc == m_lat[0] + 1) m_done_after = done_v[0];
         for (int i = 0; i < 3; i++) begin
            if (done_v[i] && m_lat[i] < 0) begin
               m_lat[i] = cyc;
               m_out[i] = out_v[i];
               m_err[i] = err_v[i];
            end
         end
         if (cyc >= pf && cyc <= pt) begin
            start = 1'b1;
            mode  = M_EQ;
            a     = 32'h5;
            b     = 32'h3;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      $display("txn mode=%03b a=%08h b=%08h | W8 cyc=%0d out=%b err=%b | W32 cyc=%0d out=%b err=%b | W1 cyc=%0d out=%b err=%b",
               m, av, bv, m_lat[0], m_out[0], m_err[0], m_lat[1], m_out[1], m_err[1],
               m_lat[2], m_out[2], m_err[2]);
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      start = 1'b0;
      mode  = M_EQ;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy_v, done_v, out_v, err_v} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b done=%b out=%b err=%b, want all 000", busy_v, done_v, out_v, err_v);
      end
      @(negedge clk);
      rst = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_signed_boundary();
      vec_t tv [5];
      tv[0] = '{M_LT,  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 2, 2, 2};
      tv[1] = '{M_LTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 2, 2, 2};
      tv[2] = '{M_GE,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 2, 2, 2};
      tv[3] = '{M_LT,  32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2, 2, 2};
      tv[4] = '{M_LTU, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 2, 2, 2};
      for (int r = 0; r < 5; r++) begin
         measure(tv[r].m, tv[r].a, tv[r].b, 0, -1);
         for (int i = 0; i < 3; i++) begin
            int el;
            el = (i == 0) ? tv[r].l8 : (i == 1) ? tv[r].l32 : tv[r].l1;
            vectors++;
            if (m_lat[i] !== el) begin
               miscompares++;
               $display("FAIL signed_lat[%0d] %s: done cycle %0d, want %0d", r, dname(i), m_lat[i], el);
            end
            vectors++;
            if (m_out[i] !== tv[r].eo) begin
               miscompares++;
               $display("FAIL signed_out[%0d] %s: out %b, want %b", r, dname(i), m_out[i], tv[r].eo);
            end
            vectors++;
            if (m_err[i] !== tv[r].ee) begin
               miscompares++;
               $display("FAIL signed_err[%0d] %s: err %b, want %b", r, dname(i), m_err[i], tv[r].ee);
            end
         end
      end
      vectors++;
      if (m_busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_cycle1 W8: busy %b, want 1", m_busy1);
      end
      vectors++;
      if (m_done_after !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse W8: done after pulse %b, want 0", m_done_after);
      end
   endtask

   task automatic test_equal_modes();
      logic [2:0] ml [6];
      logic       eo [6];
      ml = '{M_EQ, M_NE, M_LT, M_LTU, M_GE, M_GEU};
      eo = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1};
      for (int r = 0; r < 6; r++) begin
         measure(ml[r], 32'h12345678, 32'h12345678, 0, -1);
         for (int i = 0; i < 3; i++) begin
            int el;
            el = (i == 0) ? 5 : (i == 1) ? 2 : 33;
            vectors++;
            if (m_lat[i] !== el) begin
               miscompares++;
               $display("FAIL equal_lat[%0d] %s: done cycle %0d, want %0d", r, dname(i), m_lat[i], el);
            end
            vectors++;
            if (m_out[i] !== eo[r]) begin
               miscompares++;
               $display("FAIL equal_out[%0d] %s: out %b, want %b", r, dname(i), m_out[i], eo[r]);
            end
            vectors++;
            if (m_err[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL equal_err[%0d] %s: err %b, want 0", r, dname(i), m_err[i]);
            end
         end
      end
   endtask

   task automatic test_chunk0_illegal();
      vec_t tv [3];
      tv[0] = '{M_LTU, 32'h00000100, 32'h00000101, 1'b1, 1'b0, 5, 2, 33};
      tv[1] = '{M_ILL, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 5, 2, 32};
      tv[2] = '{M_LT,  32'h00000001, 32'h00000002, 1'b1, 1'b0, 5, 2, 32};
      for (int r = 0; r < 3; r++) begin
         measure(tv[r].m, tv[r].a, tv[r].b, 0, -1);
         for (int i = 0; i < 3; i++) begin
            int el;
            el = (i == 0) ? tv[r].l8 : (i == 1) ? tv[r].l32 : tv[r].l1;
            vectors++;
            if (m_lat[i] !== el) begin
               miscompares++;
               $display("FAIL chunk0_lat[%0d] %s: done cycle %0d, want %0d", r, dname(i), m_lat[i], el);
            end
            vectors++;
            if (m_out[i] !== tv[r].eo) begin
               miscompares++;
               $display("FAIL chunk0_out[%0d] %s: out %b, want %b", r, dname(i), m_out[i], tv[r].eo);
            end
            vectors++;
            if (m_err[i] !== tv[r].ee) begin
               miscompares++;
               $display("FAIL chunk0_err[%0d] %s: err %b, want %b", r, dname(i), m_err[i], tv[r].ee);
            end
         end
      end
   endtask

   task automatic test_ignore_start();
      int el [3];
      el = '{5, 2, 33};
      measure(M_LTU, 32'h00000100, 32'h00000101, 1, 3);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (m_lat[i] !== el[i] || m_out[i] !== 1'b1 || m_err[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start %s: cycle %0d out %b err %b, want cycle %0d out 1 err 0",
                     dname(i), m_lat[i], m_out[i], m_err[i], el[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int abs_cyc;
      @(negedge clk);
      start = 1'b1;
      mode  = M_EQ;
      a     = 32'h12345678;
      b     = 32'h12345678;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (cyc <= 40 && !if8.done) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      vectors++;
      if (cyc !== 5 || if8.out !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first W8: cycle %0d out %b, want cycle 5 out 1", cyc, if8.out);
      end
      abs_cyc = cyc;
      start = 1'b1;
      mode  = M_GE;
      a     = 32'hFFFFFFFF;
      b     = 32'h00000001;
      @(posedge clk);
      #1;
      start = 1'b0;
      abs_cyc++;
      cyc = 1;
      while (cyc <= 40 && !if8.done) begin
         @(posedge clk);
         #1;
         cyc++;
         abs_cyc++;
      end
      vectors++;
      if (cyc !== 2 || if8.out !== 1'b0 || if8.err !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second W8: cycle %0d out %b err %b, want cycle 2 out 0 err 0", cyc, if8.out, if8.err);
      end
      $display("txn back-to-back W8 second done cycle=%0d out=%b", cyc, if8.out);
      while (abs_cyc <= 60 && !if1.done) begin
         @(posedge clk);
         #1;
         abs_cyc++;
      end
      vectors++;
      if (abs_cyc !== 33 || if1.out !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_busy_ignore W1: cycle %0d out %b, want cycle 33 out 1", abs_cyc, if1.out);
      end
      $display("txn back-to-back W1 done cycle=%0d out=%b", abs_cyc, if1.out);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midcompare();
      int spurious;
      int el [3];
      el = '{5, 2, 33};
      // Leave out=1 on every instance so the reset visibly clears it.
      measure(M_GEU, 32'h12345678, 32'h12345678, 0, -1);
      @(negedge clk);
      start = 1'b1;
      mode  = M_EQ;
      a     = 32'h12345678;
      b     = 32'h12345678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      vectors++;
      if ({busy_v, done_v, out_v, err_v} !== 12'h000) begin
         miscompares++;
         $display("FAIL midreset_state: busy=%b done=%b out=%b err=%b, want all 000", busy_v, done_v, out_v, err_v);
      end
      spurious = 0;
      for (int c = 0; c < 40; c++) begin
         if (done_v !== 3'b000) spurious++;
         @(posedge clk);
         #1;
      end
      vectors++;
      if (spurious !== 0) begin
         miscompares++;
         $display("FAIL midreset_no_done: %0d done cycles seen, want 0", spurious);
      end
      $display("txn mid-compare reset, done cycles afterwards=%0d", spurious);
      measure(M_EQ, 32'h12345678, 32'h12345678, 0, -1);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (m_lat[i] !== el[i] || m_out[i] !== 1'b1 || m_err[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_fresh %s: cycle %0d out %b err %b, want cycle %0d out 1 err 0",
                     dname(i), m_lat[i], m_out[i], m_err[i], el[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_signed_boundary();
      test_equal_modes();
      test_chunk0_illegal();
      test_ignore_start();
      test_back_to_back();
      test_reset_midcompare();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
